// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost-full/almost-empty thresholds and optional FWFT read
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FWFT       = 0,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [CNT_W-1:0]      af_level,
    input  logic [CNT_W-1:0]      ae_level,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      data_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic wr_ack_q, overflow_q, underflow_q;
    logic wr_acc, rd_acc;

    assign full        = count_q == DEPTH_C;
    assign empty       = count_q == '0;
    assign almostfull  = count_q >= af_level && count_q < DEPTH_C;
    assign almostempty = count_q != '0 && count_q <= ae_level;
    assign data_count  = count_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign wr_acc      = wr_en && !full;
    assign rd_acc      = rd_en && !empty;

    // next pointers wrap at the last entry so non-power-of-two depths work; count moves only on one-sided traffic
    always_comb begin
        wr_ptr_d = wr_acc ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = rd_acc ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d  = (wr_acc && !rd_acc) ? count_q + CNT_W'(1) :
                   (rd_acc && !wr_acc) ? count_q - CNT_W'(1) : count_q;
    end

    // occupancy state and one-cycle handshake pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
        end
    end

    // storage is not reset; stale words become unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr_q];
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            // registered read port, holds its word when no read is accepted
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dout_q <= '0;
                else if (rd_acc) dout_q <= mem[rd_ptr_q];
            end
            assign data_out = dout_q;
        end
    endgenerate
endmodule
